seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display.
- Holds a 32-bit display word plus 4-bit per-digit extend codes.
- Walks digits 0..7 with an inter-digit blanking gap.
- Feeds one shared hex-to-segment decoder (hex, extend, flash inputs); generates the flash blink clock.
- Frame-synchronous update: CPU/bus writes never tear a displayed frame.

Parameters:
- DIGIT_CYCLES, 50000, clk cycles each digit is lit (>=1).
- BLANK_CYCLES, 500, clk cycles all anodes off between digits (0 = no blank state).
- FLASH_FRAMES, 32, frames per flash half-period (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- wr_en  in  1  write strobe, one cycle.
- wr_data  in  32  nibble i = digit i value; digit 0 = bits[3:0], rightmost.
- wr_ext  in  32  nibble i = extend code for digit i.
- upd_pending  out  1  shadow written, not yet committed.
- an  out  8  digit anodes, low active; an[i] = digit i.
- hex  out  4  nibble to decoder.
- extend  out  4  extend code to decoder.
- flash  out  1  blink phase to decoder; 1 = flashing digits dark.
- digit_idx  out  3  currently scanned digit.
- frame_tick  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Outputs on reset: an=8'hFF, hex=0, extend=4'b0111, flash=0, digit_idx=0, frame_tick=0, upd_pending=0.
  - Internal on reset: display and shadow regs 0, phase/flash counters 0, state LIT.
  - Reset mid-frame aborts the scan immediately; first LIT period after release shows digit 0 of the zeroed display.
- All outputs registered.
- States:
  - LIT: an = ~(1<<digit_idx), hex = disp_data[4*idx+:4], extend = disp_ext[4*idx+:4]. Lasts exactly DIGIT_CYCLES cycles, then -> BLANK; if BLANK_CYCLES=0, -> next digit's LIT.
  - BLANK: an=8'hFF, extend=4'b0111, hex holds. Lasts exactly BLANK_CYCLES cycles, then digit_idx increments (7 wraps to 0) -> LIT.
  - Frame length = 8*(DIGIT_CYCLES+BLANK_CYCLES) cycles.
- Frame end = last cycle of digit 7's LIT+BLANK period:
  - frame_tick=1 for exactly that cycle.
  - Commit: if upd_pending, shadow -> display regs, upd_pending cleared. First LIT of digit 0 shows new data.
- Writes:
  - wr_en loads wr_data/wr_ext into shadow and sets upd_pending next cycle.
  - Repeated writes before commit: last write wins.
  - wr_en on the frame-end cycle: wr_data/wr_ext bypass straight into display regs, upd_pending=0.
  - No back-pressure; writes always accepted.
- Flash:
  - Frame counter 0..FLASH_FRAMES-1 increments on frame_tick.
  - On frame_tick with counter = FLASH_FRAMES-1: counter wraps to 0, flash toggles.
  - Period = 2*FLASH_FRAMES frames.
  - flash is forwarded unconditionally; only digits whose extend[3]=1 react in the decoder.
- extend code 3'b111 in a digit nibble blanks that digit (decoder behaviour). The controller does not alter it except as in the Optional Feature.

Optional Feature:
- Macro: SEG_SCAN_LZ_BLANK_EN.
- Defined: leading-zero suppression. Digits from 7 downward whose committed hex=0 are output with extend[2:0]=3'b111 (extend[3] preserved). Suppression stops at the first digit that is nonzero or has extend[2:0]!=0. Digit 0 is never suppressed. Evaluated on committed display data.
- Undefined: extend passes through unchanged; no extra logic.

Test Plan (DIGIT_CYCLES=4, BLANK_CYCLES=2, FLASH_FRAMES=2):
- Reset release, no writes -> an sequence FE(4 cyc), FF(2), FD(4), FF(2) ... 7F; frame_tick every 48 cycles; hex=0 throughout.
- wr_en with wr_data=32'h89ABCDEF, wr_ext=0 mid-frame -> upd_pending=1; current frame still shows 0. After frame_tick: digit0 hex=F ... digit7 hex=8; upd_pending=0.
- Two writes h11111111 then h22222222 in same frame -> only h22222222 ever displayed.
- wr_en on frame_tick cycle with h5A5A5A5A -> displayed in the immediately following frame; upd_pending stays 0.
- Count frame_ticks -> flash toggles after 2nd, 4th, 6th tick. With wr_ext=32'h00000008, extend=4'h8 on digit 0 only.
- Assert rst during digit 5 LIT -> same cycle: an=FF, extend=0111, flash=0. After release, scan restarts at digit 0. With SEG_SCAN_LZ_BLANK_EN and data h00000120: digits 7..3 extend=0111, digits 2..0 extend=0000.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Scan controller for the 8-digit common-anode seven-segment display, with frame-synchronous updates.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int FLASH_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [31:0] wr_ext,
    output logic        upd_pending,
    output logic [7:0]  an,
    output logic [3:0]  hex,
    output logic [3:0]  extend,
    output logic        flash,
    output logic [2:0]  digit_idx,
    output logic        frame_tick
);

    typedef enum logic {
        ST_LIT,
        ST_BLANK
    } state_t;

    localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int FW   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [FW-1:0] FL_LAST  = FW'(FLASH_FRAMES - 1);

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] disp_data_q, disp_data_d;
    logic [31:0] disp_ext_q, disp_ext_d;
    logic [31:0] shad_data_q, shad_data_d;
    logic [31:0] shad_ext_q, shad_ext_d;
    logic        pend_q, pend_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic        flash_q, flash_d;
    logic [7:0]  an_q, an_d;
    logic [3:0]  hex_q, hex_d;
    logic [3:0]  ext_q, ext_d;
    logic [2:0]  didx_q, didx_d;
    logic        tick_q, tick_d;
    logic [3:0]  lit_ext;

    // The internal scan runs one cycle ahead of the registered outputs, so tick_q
    // marks the visible frame-end cycle and commits/bypasses land exactly there.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        tick_d      = 1'b0;
        disp_data_d = disp_data_q;
        disp_ext_d  = disp_ext_q;
        shad_data_d = shad_data_q;
        shad_ext_d  = shad_ext_q;
        pend_d      = pend_q;
        fcnt_d      = fcnt_q;
        flash_d     = flash_q;

        unique case (state_q)
            ST_LIT: begin
                if (cnt_q == DIG_LAST) begin
                    cnt_d = '0;
                    if (BLANK_CYCLES == 0) begin
                        idx_d  = idx_q + 3'd1;
                        tick_d = (idx_q == 3'd7);
                    end else begin
                        state_d = ST_BLANK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BLANK: begin
                if (cnt_q == BLK_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LIT;
                    idx_d   = idx_q + 3'd1;
                    tick_d  = (idx_q == 3'd7);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_LIT;
        endcase

        if (tick_q) begin
            pend_d = 1'b0;
            if (wr_en) begin
                disp_data_d = wr_data;
                disp_ext_d  = wr_ext;
            end else if (pend_q) begin
                disp_data_d = shad_data_q;
                disp_ext_d  = shad_ext_q;
            end
            if (fcnt_q == FL_LAST) begin
                fcnt_d  = '0;
                flash_d = ~flash_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end else if (wr_en) begin
            shad_data_d = wr_data;
            shad_ext_d  = wr_ext;
            pend_d      = 1'b1;
        end
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    logic [7:0] lz_sup;
    logic       lz_run;
    logic [3:0] cur_ext;

    // Suppression walks down from digit 7 and stops at the first significant digit.
    always_comb begin
        lz_run = 1'b1;
        lz_sup = '0;
        for (int i = 7; i >= 1; i--) begin
            if (lz_run && (disp_data_d[4*i +: 4] == 4'h0) && (disp_ext_d[4*i +: 3] == 3'b000)) begin
                lz_sup[i] = 1'b1;
            end else begin
                lz_run = 1'b0;
            end
        end
        cur_ext = disp_ext_d[{idx_q, 2'b00} +: 4];
        lit_ext = lz_sup[idx_q] ? {cur_ext[3], 3'b111} : cur_ext;
    end
`else
    assign lit_ext = disp_ext_d[{idx_q, 2'b00} +: 4];
`endif

    always_comb begin
        an_d   = 8'hFF;
        hex_d  = hex_q;
        ext_d  = 4'b0111;
        didx_d = idx_q;
        if (state_q == ST_LIT) begin
            an_d  = ~(8'h01 << idx_q);
            hex_d = disp_data_d[{idx_q, 2'b00} +: 4];
            ext_d = lit_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LIT;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            disp_data_q <= '0;
            disp_ext_q  <= '0;
            shad_data_q <= '0;
            shad_ext_q  <= '0;
            pend_q      <= 1'b0;
            fcnt_q      <= '0;
            flash_q     <= 1'b0;
            an_q        <= 8'hFF;
            hex_q       <= 4'h0;
            ext_q       <= 4'b0111;
            didx_q      <= 3'd0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            disp_data_q <= disp_data_d;
            disp_ext_q  <= disp_ext_d;
            shad_data_q <= shad_data_d;
            shad_ext_q  <= shad_ext_d;
            pend_q      <= pend_d;
            fcnt_q      <= fcnt_d;
            flash_q     <= flash_d;
            an_q        <= an_d;
            hex_q       <= hex_d;
            ext_q       <= ext_d;
            didx_q      <= didx_d;
            tick_q      <= tick_d;
        end
    end

    assign upd_pending = pend_q;
    assign an          = an_q;
    assign hex         = hex_q;
    assign extend      = ext_q;
    assign flash       = flash_q;
    assign digit_idx   = didx_q;
    assign frame_tick  = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with short scan timing (4 lit, 2 blank, flash every 2 frames).
module tb_seg_scan_ctrl;

    localparam int DigitCycles = 4;
    localparam int BlankCycles = 2;
    localparam int FlashFrames = 2;
    localparam int SlotCycles  = DigitCycles + BlankCycles;
    localparam int FrameCycles = 8 * SlotCycles;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrEn = 1'b0;
    logic [31:0] wrData = '0;
    logic [31:0] wrExt = '0;
    logic        updPending;
    logic [7:0]  an;
    logic [3:0]  hex;
    logic [3:0]  extend;
    logic        flash;
    logic [2:0]  digitIdx;
    logic        frameTick;

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] dispModel, extModel, shadData, shadExt;
    logic        pendModel, flashModel;
    int          frameCount;

    seg_scan_ctrl #(
        .DIGIT_CYCLES(DigitCycles),
        .BLANK_CYCLES(BlankCycles),
        .FLASH_FRAMES(FlashFrames)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wrEn),
        .wr_data(wrData),
        .wr_ext(wrExt),
        .upd_pending(updPending),
        .an(an),
        .hex(hex),
        .extend(extend),
        .flash(flash),
        .digit_idx(digitIdx),
        .frame_tick(frameTick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Expected extend code of a lit digit, from the bench's own copy of the committed display.
    function automatic logic [3:0] expectedExtend(input int digit);
        logic [3:0] e;
        e = extModel[4*digit +: 4];
`ifdef SEG_SCAN_LZ_BLANK_EN
        begin
            logic sup;
            sup = (digit != 0);
            for (int j = 7; j >= digit; j--) begin
                if (dispModel[4*j +: 4] != 4'h0 || extModel[4*j +: 3] != 3'b000) sup = 1'b0;
            end
            if (sup) e = {e[3], 3'b111};
        end
`endif
        return e;
    endfunction

    task automatic resetModel();
        dispModel  = '0;
        extModel   = '0;
        shadData   = '0;
        shadExt    = '0;
        pendModel  = 1'b0;
        flashModel = 1'b0;
        frameCount = 0;
    endtask

    task automatic checkResetState(input string when);
        checkOutput($sformatf("%s an", when), {24'h0, an}, 32'hFF);
        checkOutput($sformatf("%s hex", when), {28'h0, hex}, 32'h0);
        checkOutput($sformatf("%s extend", when), {28'h0, extend}, 32'h7);
        checkOutput($sformatf("%s flash", when), {31'h0, flash}, 32'h0);
        checkOutput($sformatf("%s digit_idx", when), {29'h0, digitIdx}, 32'h0);
        checkOutput($sformatf("%s frame_tick", when), {31'h0, frameTick}, 32'h0);
        checkOutput($sformatf("%s upd_pending", when), {31'h0, updPending}, 32'h0);
    endtask

    // Runs numCycles of a frame (cycle 0 = first lit cycle of digit 0), checking every
    // output each cycle and issuing up to two writes at the given cycles (-1 = none).
    task automatic applyStimulus(input int numCycles,
                                 input int wrCycA, input logic [31:0] dataA, input logic [31:0] extA,
                                 input int wrCycB, input logic [31:0] dataB, input logic [31:0] extB);
        int         digit;
        int         pos;
        logic       lit;
        logic [7:0] expAn;
        logic [3:0] expExt;
        for (int c = 0; c < numCycles; c++) begin
            @(negedge clk);
            digit = c / SlotCycles;
            pos   = c % SlotCycles;
            lit   = (pos < DigitCycles);
            expAn  = lit ? ~(8'h01 << digit) : 8'hFF;
            expExt = lit ? expectedExtend(digit) : 4'b0111;
            checkOutput($sformatf("an f%0d c%0d", frameCount, c), {24'h0, an}, {24'h0, expAn});
            checkOutput($sformatf("hex f%0d c%0d", frameCount, c), {28'h0, hex}, {28'h0, dispModel[4*digit +: 4]});
            checkOutput($sformatf("extend f%0d c%0d", frameCount, c), {28'h0, extend}, {28'h0, expExt});
            checkOutput($sformatf("digit_idx f%0d c%0d", frameCount, c), {29'h0, digitIdx}, digit);
            checkOutput($sformatf("frame_tick f%0d c%0d", frameCount, c), {31'h0, frameTick}, (c == FrameCycles - 1) ? 32'h1 : 32'h0);
            checkOutput($sformatf("upd_pending f%0d c%0d", frameCount, c), {31'h0, updPending}, {31'h0, pendModel});
            checkOutput($sformatf("flash f%0d c%0d", frameCount, c), {31'h0, flash}, {31'h0, flashModel});

            if (c == wrCycA) begin
                wrEn = 1'b1; wrData = dataA; wrExt = extA;
            end else if (c == wrCycB) begin
                wrEn = 1'b1; wrData = dataB; wrExt = extB;
            end else begin
                wrEn = 1'b0;
            end

            if (c == FrameCycles - 1) begin
                frameCount++;
                if (wrEn) begin
                    dispModel = wrData;
                    extModel  = wrExt;
                end else if (pendModel) begin
                    dispModel = shadData;
                    extModel  = shadExt;
                end
                pendModel = 1'b0;
                if (frameCount % FlashFrames == 0) flashModel = ~flashModel;
            end else if (wrEn) begin
                shadData  = wrData;
                shadExt   = wrExt;
                pendModel = 1'b1;
            end
        end
    endtask

    initial begin
        resetModel();
        repeat (2) @(negedge clk);
        checkResetState("por");
        rst = 1'b0;

        applyStimulus(FrameCycles, -1, 32'h0, 32'h0, -1, 32'h0, 32'h0);
        applyStimulus(FrameCycles, 10, 32'h89ABCDEF, 32'h0, -1, 32'h0, 32'h0);
        applyStimulus(FrameCycles, 5, 32'h11111111, 32'h0, 20, 32'h22222222, 32'h00000008);
        applyStimulus(FrameCycles, FrameCycles - 1, 32'h5A5A5A5A, 32'h0, -1, 32'h0, 32'h0);
        applyStimulus(FrameCycles, 3, 32'h00000120, 32'h0, -1, 32'h0, 32'h0);
        applyStimulus(FrameCycles, -1, 32'h0, 32'h0, -1, 32'h0, 32'h0);

        // Stop partway through digit 5's lit period and reset asynchronously.
        applyStimulus(5 * SlotCycles + 2, -1, 32'h0, 32'h0, -1, 32'h0, 32'h0);
        wrEn = 1'b0;
        rst = 1'b1;
        #1;
        resetModel();
        checkResetState("mid");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(FrameCycles, -1, 32'h0, 32'h0, -1, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
